// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer: exhaustive sweep-and-check engine for an
// N_IN-input, 1-output combinational datapath.
//
// Parameters:
//   N_IN        number of datapath inputs (sweep covers 2**N_IN vectors)
//   HOLD_CYCLES cycles each vector is held; sampled on the last one
//   EXPECTED    golden truth table, bit i = expected output of vector i
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   start         sweep request, sampled only in IDLE
//   abort         drops an APPLY sweep back to IDLE without done
//   dut_in        vector driven to the datapath (0 outside APPLY)
//   dut_out       datapath response
//   busy          high while vectors are being applied
//   done          one-cycle pulse at sweep end
//   result_tt     captured truth table
//   err_count     number of mismatching vectors
//   first_err_idx index of first mismatch (valid when err_count != 0)
//   pass          last completed sweep had no mismatches
//
// Build option:
//   TT_SEQ_STOP_ON_ERR_EN  first mismatch ends the sweep early

module truth_table_sequencer #(
    parameter int                 N_IN        = 4,
    parameter int                 HOLD_CYCLES = 2,
    parameter logic [2**N_IN-1:0] EXPECTED    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      dut_in,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   result_tt,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_err_idx,
    output logic                 pass
);

    localparam int NV = 2**N_IN;
    localparam int CW = N_IN + 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] VEC_LAST  = N_IN'(NV - 1);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DONE
    } state_t;

    state_t          state;
    logic [N_IN-1:0] vec;
    logic [HW-1:0]   hold;

    logic sample_now;
    logic mismatch;
    logic last_vec;
    logic stop_now;

    assign sample_now = (hold == HOLD_LAST);
    assign mismatch   = (dut_out != EXPECTED[vec]);
    assign last_vec   = (vec == VEC_LAST);

`ifdef TT_SEQ_STOP_ON_ERR_EN
    // A mismatch ends the sweep on the same sampling edge.
    assign stop_now = last_vec || mismatch;
`else
    assign stop_now = last_vec;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            vec           <= '0;
            hold          <= '0;
            dut_in        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            result_tt     <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            pass          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= APPLY;
                        busy          <= 1'b1;
                        vec           <= '0;
                        hold          <= '0;
                        dut_in        <= '0;
                        result_tt     <= '0;
                        err_count     <= '0;
                        first_err_idx <= '0;
                        pass          <= 1'b0;
                    end
                end

                APPLY: begin
                    if (abort) begin
                        // Partial results are kept; no sample this edge.
                        state  <= IDLE;
                        busy   <= 1'b0;
                        vec    <= '0;
                        hold   <= '0;
                        dut_in <= '0;
                        pass   <= 1'b0;
                    end else if (sample_now) begin
                        result_tt[vec] <= dut_out;
                        if (mismatch) begin
                            err_count <= err_count + CW'(1);
                            if (err_count == '0) begin
                                first_err_idx <= vec;
                            end
                        end
                        hold <= '0;
                        if (stop_now) begin
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                            vec    <= '0;
                            dut_in <= '0;
                        end else begin
                            vec    <= vec + N_IN'(1);
                            dut_in <= vec + N_IN'(1);
                        end
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end

                DONE: begin
                    // err_count already includes the final sample here.
                    done  <= 1'b0;
                    pass  <= (err_count == '0);
                    state <= IDLE;
                end

                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b0;
                    dut_in <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// tb_truth_table_sequencer: scoreboard bench for truth_table_sequencer.
// Datapath modes: 0 = 4-input AND, 1 = stuck at 0, 2 = 4-input OR.

module tb_truth_table_sequencer;

    localparam int          N_IN = 4;
    localparam int          HOLD = 2;
    localparam logic [15:0] EXP  = 16'h8000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [3:0]  dut_in;
    logic        dut_out;
    logic        busy;
    logic        done;
    logic [15:0] result_tt;
    logic [4:0]  err_count;
    logic [3:0]  first_err_idx;
    logic        pass;

    int mode;
    int checks;
    int errors;

    typedef struct {
        logic [15:0] tt;
        int          ec;
        int          fe;
        logic        ps;
        int          lat;
    } exp_t;

    exp_t sb[$];

    truth_table_sequencer #(
        .N_IN(N_IN),
        .HOLD_CYCLES(HOLD),
        .EXPECTED(EXP)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .dut_in(dut_in),
        .dut_out(dut_out),
        .busy(busy),
        .done(done),
        .result_tt(result_tt),
        .err_count(err_count),
        .first_err_idx(first_err_idx),
        .pass(pass)
    );

    assign dut_out = (mode == 0) ? (&dut_in) :
                     (mode == 1) ? 1'b0 : (|dut_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic dp(input int m, input int v);
        logic [3:0] x;
        x = 4'(v);
        if (m == 0) return &x;
        if (m == 1) return 1'b0;
        return |x;
    endfunction

    function automatic exp_t model(input int m);
        exp_t e;
        logic o;
        e.tt = '0;
        e.ec = 0;
        e.fe = 0;
        e.lat = 16 * HOLD + 1;
        for (int v = 0; v < 16; v++) begin
            o = dp(m, v);
            e.tt[v] = o;
            if (o != EXP[v]) begin
                if (e.ec == 0) e.fe = v;
                e.ec++;
`ifdef TT_SEQ_STOP_ON_ERR_EN
                e.lat = (v + 1) * HOLD + 1;
                break;
`endif
            end
        end
        e.ps = (e.ec == 0);
        return e;
    endfunction

    // Caller leaves start high at the current negedge.
    task automatic wait_sweep(input int hold_start,
                              input int pulse_at,
                              output int lat);
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == hold_start) start = 1'b0;
            if (c == pulse_at) start = 1'b1;
            if (c == pulse_at + 1) start = 1'b0;
            if (done) begin
                lat = c;
                break;
            end
            chk("busy_apply", busy, 1);
            chk("dut_in", dut_in, (c - 1) / HOLD);
        end
        start = 1'b0;
        if (lat == 0) chk("timeout", 0, 1);
    endtask

    task automatic finish_sweep(input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("latency", lat, e.lat);
        chk("busy_done", busy, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("result_tt", result_tt, e.tt);
        chk("err_count", err_count, e.ec);
        if (e.ec != 0) chk("first_err", first_err_idx, e.fe);
        chk("pass", pass, e.ps);
        chk("dut_in_idle", dut_in, 0);
    endtask

    task automatic run(input int m);
        int lat;
        mode = m;
        start = 1'b1;
        sb.push_back(model(m));
        wait_sweep(1, 0, lat);
        finish_sweep(lat);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_dut_in", dut_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tt", result_tt, 0);
        chk("rst_ec", err_count, 0);
        chk("rst_fe", first_err_idx, 0);
        chk("rst_pass", pass, 0);
    endtask

    initial begin
        int lat;
        int dn;
        checks = 0;
        errors = 0;
        mode = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);

        run(0);

        // abort at cycle 7 with start held high
        mode = 0;
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 7) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_dut_in", dut_in, 0);
        sb.push_back(model(0));
        wait_sweep(2, 20, lat);
        finish_sweep(lat);
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy || done) dn++;
        end
        chk("no_second_sweep", dn, 0);

        run(1);
        run(2);

        // reset low at cycle 10 of a sweep
        mode = 0;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rst_no_done", dn, 0);

        run(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
